// File: rtl/draw_cmdfifo.sv
// draw_cmdfifo: command FIFO between the DRAWCMD register write port and the
// draw VRAM controller.
//
// Handshake: a push happens on any cycle with REG_WE high while the FIFO is not
// full; a pop happens on any cycle with CMD_RD_EN high while it is not empty.
// There is no back-pressure; the writer and reader watch CMD_FULL and CMD_EMPTY
// themselves. A popped word appears on CMD_RDATA on the following cycle and
// stays there until the next successful pop. A refused push sets CMD_OVF and a
// refused pop sets CMD_UDF. Both flags stay set until ARST or REG_CLR.
// REG_CLR takes priority over both strobes in the same cycle.
//
// Optional feature, enabled by defining DRAW_CMDFIFO_HWM_EN: a high-water mark
// register on CMD_HWM. When the macro is undefined, CMD_HWM is tied to zero and
// no register is built.
module draw_cmdfifo #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DWIDTH     = 32
) (
  input  logic                  CLK,
  input  logic                  ARST,
  input  logic                  REG_CLR,
  input  logic                  REG_WE,
  input  logic [DWIDTH-1:0]     REG_WDATA,
  input  logic                  CMD_RD_EN,
  output logic [DWIDTH-1:0]     CMD_RDATA,
  output logic                  CMD_EMPTY,
  output logic                  CMD_FULL,
  output logic [DEPTH_LOG2:0]   CMD_COUNT,
  output logic                  CMD_OVF,
  output logic                  CMD_UDF,
  output logic [DEPTH_LOG2:0]   CMD_HWM
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Storage is a simple dual-port RAM with a synchronous read, so it maps onto
  // block RAM. It is deliberately never reset.
  logic [DWIDTH-1:0] mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic [DWIDTH-1:0]     rdata;
  logic                  ovf;
  logic                  udf;

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;
  logic push_drop;
  logic pop_drop;

  // Occupancy flags are decoded only from the registered count.
  assign empty = (count == CNT_ZERO);
  assign full  = (count == CNT_FULL);

  // Accept or refuse each strobe. A flush suppresses both strobes.
  // Pop-while-empty never falls through to a word written in the same cycle.
  always_comb begin
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    push_drop = 1'b0;
    pop_drop  = 1'b0;
    if (!REG_CLR) begin
      push_ok   = REG_WE && !full;
      push_drop = REG_WE && full;
      pop_ok    = CMD_RD_EN && !empty;
      pop_drop  = CMD_RD_EN && empty;
    end
  end

  // Next word count: +1 on a push alone, -1 on a pop alone, and 0 on a flush.
  always_comb begin
    count_nxt = count;
    if (REG_CLR) begin
      count_nxt = CNT_ZERO;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // RAM write port. Because a write never targets an unread word, a write and
  // a read at the same cycle cannot use the same live address.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wptr] <= REG_WDATA;
    end
  end

  // RAM read port and output register. The output holds its value between
  // successful pops and through a flush.
  always_ff @(posedge CLK) begin
    if (ARST) begin
      rdata <= '0;
    end else if (pop_ok) begin
      rdata <= mem[rptr];
    end
  end

  // Pointers and count. The pointers wrap modulo the depth.
  always_ff @(posedge CLK) begin
    if (ARST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (REG_CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  // Sticky error flags. They clear only on reset or on a flush.
  always_ff @(posedge CLK) begin
    if (ARST || REG_CLR) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_drop) ovf <= 1'b1;
      if (pop_drop)  udf <= 1'b1;
    end
  end

`ifdef DRAW_CMDFIFO_HWM_EN
  logic [DEPTH_LOG2:0] hwm;

  // High-water mark: tracks the largest count seen since the last reset or flush.
  always_ff @(posedge CLK) begin
    if (ARST || REG_CLR) begin
      hwm <= '0;
    end else if (count_nxt > hwm) begin
      hwm <= count_nxt;
    end
  end

  assign CMD_HWM = hwm;
`else
  assign CMD_HWM = '0;
`endif

  assign CMD_RDATA = rdata;
  assign CMD_EMPTY = empty;
  assign CMD_FULL  = full;
  assign CMD_COUNT = count;
  assign CMD_OVF   = ovf;
  assign CMD_UDF   = udf;

endmodule

// File: tb/tb_draw_cmdfifo.sv
// tb_draw_cmdfifo: directed and randomized bench for draw_cmdfifo. The
// reference model is a queue of words with an output word, the sticky flags and
// a high-water value.
module tb_draw_cmdfifo;

  localparam int DL2   = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << DL2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            ARST      = 1'b1;
  logic            REG_CLR   = 1'b0;
  logic            REG_WE    = 1'b0;
  logic [DW-1:0]   REG_WDATA = '0;
  logic            CMD_RD_EN = 1'b0;
  logic [DW-1:0]   CMD_RDATA;
  logic            CMD_EMPTY;
  logic            CMD_FULL;
  logic [DL2:0]    CMD_COUNT;
  logic            CMD_OVF;
  logic            CMD_UDF;
  logic [DL2:0]    CMD_HWM;

  draw_cmdfifo #(.DEPTH_LOG2(DL2), .DWIDTH(DW)) dut (
    .CLK       (CLK),
    .ARST      (ARST),
    .REG_CLR   (REG_CLR),
    .REG_WE    (REG_WE),
    .REG_WDATA (REG_WDATA),
    .CMD_RD_EN (CMD_RD_EN),
    .CMD_RDATA (CMD_RDATA),
    .CMD_EMPTY (CMD_EMPTY),
    .CMD_FULL  (CMD_FULL),
    .CMD_COUNT (CMD_COUNT),
    .CMD_OVF   (CMD_OVF),
    .CMD_UDF   (CMD_UDF),
    .CMD_HWM   (CMD_HWM)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_ovf   = 1'b0;
  logic          exp_udf   = 1'b0;
  int            exp_hwm   = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"}, 32'(CMD_COUNT), 32'(n));
    check({tag, ".empty"}, 32'(CMD_EMPTY), 32'(n == 0));
    check({tag, ".full"},  32'(CMD_FULL),  32'(n == DEPTH));
    check({tag, ".rdata"}, CMD_RDATA, exp_rdata);
    check({tag, ".ovf"},   32'(CMD_OVF),   32'(exp_ovf));
    check({tag, ".udf"},   32'(CMD_UDF),   32'(exp_udf));
`ifdef DRAW_CMDFIFO_HWM_EN
    check({tag, ".hwm"},   32'(CMD_HWM),   32'(exp_hwm));
`else
    check({tag, ".hwm"},   32'(CMD_HWM),   32'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of strobes, advance the model on the edge, then compare.
  task automatic step(input string tag, input logic we, input logic [DW-1:0] wd,
                      input logic rd, input logic clr);
    int n0;
    REG_WE    = we;
    REG_WDATA = wd;
    CMD_RD_EN = rd;
    REG_CLR   = clr;
    @(posedge CLK);
    n0 = exp_q.size();
    if (clr) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      exp_hwm = 0;
    end else begin
      if (rd) begin
        if (n0 > 0) exp_rdata = exp_q.pop_front();
        else        exp_udf = 1'b1;
      end
      if (we) begin
        if (n0 < DEPTH) exp_q.push_back(wd);
        else            exp_ovf = 1'b1;
      end
      if (exp_q.size() > exp_hwm) exp_hwm = exp_q.size();
    end
    #1;
    REG_WE    = 1'b0;
    CMD_RD_EN = 1'b0;
    REG_CLR   = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    ARST      = 1'b1;
    REG_WE    = 1'b0;
    CMD_RD_EN = 1'b0;
    REG_CLR   = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    exp_q.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    exp_hwm   = 0;
    #1;
    ARST = 1'b0;
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] t1_words [3];

  initial begin
    t1_words[0] = 32'h0000_0020;
    t1_words[1] = 32'h0000_0000;
    t1_words[2] = 32'h0280_01E0;

    do_reset("reset");

    // Three writes, then three reads, in order with one-cycle latency.
    for (int i = 0; i < 3; i++) step("t1_wr", 1'b1, t1_words[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t1_rd", 1'b0, '0, 1'b1, 1'b0);

    // Fill the FIFO, overflow with one more word, then drain it.
    for (int i = 0; i < DEPTH; i++) step("t2_fill", 1'b1, DW'(i), 1'b0, 1'b0);
    step("t2_ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step("t2_full_both", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("t2_drain", 1'b0, '0, 1'b1, 1'b0);

    // A read while empty sets UDF and leaves RDATA unchanged.
    step("t3_wr", 1'b1, 32'h0000_000F, 1'b0, 1'b0);
    step("t3_rd", 1'b0, '0, 1'b1, 1'b0);
    step("t3_udf", 1'b0, '0, 1'b1, 1'b0);
    step("t3_empty_both", 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    step("t3_rd2", 1'b0, '0, 1'b1, 1'b0);

    // Streaming through the pointer wrap with the count held at 5.
    for (int i = 0; i < 5; i++) step("t4_pre", 1'b1, 32'hA000_0000 + DW'(i), 1'b0, 1'b0);
    for (int i = 5; i < 1100; i++) step("t4_stream", 1'b1, 32'hA000_0000 + DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("t4_drain", 1'b0, '0, 1'b1, 1'b0);

    // A flush takes priority over a write and a read in the same cycle.
    for (int i = 0; i < 7; i++) step("t5_pre", 1'b1, 32'hB000_0000 + DW'(i), 1'b0, 1'b0);
    step("t5_clr", 1'b1, 32'hBAD0_0000, 1'b1, 1'b1);
    step("t5_wr", 1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    step("t5_rd", 1'b0, '0, 1'b1, 1'b0);

    // High-water mark: 9 pushes, 4 pops, 2 pushes, then a flush.
    step("t6_clr", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("t6_push", 1'b1, 32'hD000_0000 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("t6_pop", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step("t6_push2", 1'b1, 32'hD100_0000 + DW'(i), 1'b0, 1'b0);
    step("t6_clr2", 1'b0, '0, 1'b0, 1'b1);

    // Randomized phases with mixed write and read rates.
    for (int ph = 0; ph < 6; ph++) begin
      int p_we;
      int p_rd;
      p_we = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
      p_rd = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 90;
      if (ph == 3) do_reset("rand_reset");
      for (int c = 0; c < 1500; c++) begin
        step("rand",
             $urandom_range(99, 0) < p_we,
             $urandom,
             $urandom_range(99, 0) < p_rd,
             $urandom_range(255, 0) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
